// File: rtl/pool_wr_pack.sv
// Packs the pooled byte stream into MEM_DATA_BUS words written to consecutive aligned addresses.
// Latency: the byte that completes a word (or carries pool_last) raises mem_wr_req in the following cycle.
// Backpressure: pool_ready is high only in FILL, so upstream holds its byte while a write waits for mem_wr_gnt.
module pool_wr_pack #(
    parameter int ADDR_WIDTH     = 12,
    parameter int MEM_DATA_BUS   = 128,
    parameter int BYTES_PER_WORD = MEM_DATA_BUS / 8,
    parameter int LOG2_BPW       = $clog2(BYTES_PER_WORD)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     sw_pool_wr_addr,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic                      pool_valid,
    input  logic [7:0]                pool_data,
    input  logic                      pool_last,
    output logic                      pool_ready,
    output logic                      mem_wr_req,
    output logic [ADDR_WIDTH-1:0]     mem_wr_addr,
    output logic [MEM_DATA_BUS-1:0]   mem_wr_data,
    output logic [BYTES_PER_WORD-1:0] mem_wr_be,
    input  logic                      mem_wr_gnt
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [MEM_DATA_BUS-1:0]   data_q, data_d;
    logic [BYTES_PER_WORD-1:0] be_q, be_d;
    logic [LOG2_BPW-1:0]       byte_cnt_q, byte_cnt_d;
    logic                      last_q, last_d;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        data_d     = data_q;
        be_d       = be_q;
        byte_cnt_d = byte_cnt_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Base is forced onto a word boundary by discarding the lane-offset bits.
                    wr_ptr_d   = (sw_pool_wr_addr >> LOG2_BPW) << LOG2_BPW;
                    data_d     = '0;
                    be_d       = '0;
                    byte_cnt_d = '0;
                    last_d     = 1'b0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (pool_valid) begin
                    data_d[{byte_cnt_q, 3'b000} +: 8] = pool_data;
                    be_d[byte_cnt_q]                  = 1'b1;
                    byte_cnt_d                        = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LOG2_BPW'(BYTES_PER_WORD - 1) || pool_last) begin
                        last_d  = pool_last;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (mem_wr_gnt) begin
                    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(BYTES_PER_WORD);
                    data_d     = '0;
                    be_d       = '0;
                    byte_cnt_d = '0;
                    last_d     = 1'b0;
                    state_d    = last_q ? DONE : FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            data_q     <= '0;
            be_q       <= '0;
            byte_cnt_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            byte_cnt_q <= byte_cnt_d;
            last_q     <= last_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign pool_ready  = (state_q == FILL);
    assign mem_wr_req  = (state_q == WRITE);
    assign mem_wr_addr = wr_ptr_q;
    assign mem_wr_data = data_q;
    assign mem_wr_be   = be_q;

endmodule
